// File: rtl/pipeline_stage_chain.sv
// pipeline_stage_chain: elastic register chain of STAGES slots with valid/ready at both
// ends, global stall (freeze), per-stage flush and a registered occupancy count.
// Optional performance counters (stall_cnt, bubble_cnt) are built when PIPE_PERF_EN is defined.
module pipeline_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  localparam int CNT_W = $clog2(STAGES + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic              stall,
  input  logic [STAGES-1:0] flush,
  output logic [CNT_W-1:0]  occupancy
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  function automatic logic [CNT_W-1:0] popcount(input logic [STAGES-1:0] bits);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < STAGES; i++) n = n + CNT_W'(bits[i]);
    return n;
  endfunction

`ifdef PIPE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction
`endif

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vld_nxt;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] arrive;
  logic [STAGES-1:0] leave;
  logic [STAGES:0]   rdy;
  logic [WIDTH-1:0]  dat [STAGES];
  logic [WIDTH-1:0]  src [STAGES];
  logic              in_fire;

  // Ready ripples back from the consumer: a stage can take data if empty or if it drains.
  always_comb begin
    logic r;
    r = out_ready;
    rdy[STAGES] = r;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r = !vld[i] || r;
      rdy[i] = r;
    end
  end

  assign in_ready  = rdy[0] && !stall;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld[STAGES-1] && !flush[STAGES-1];
  assign out_data  = dat[STAGES-1];

  // Next valid state per stage: flush wins over everything, stall freezes, else advance.
  always_comb begin
    vld_nxt = vld;
    load    = '0;
    arrive  = '0;
    leave   = '0;
    src[0]  = in_data;
    arrive[0] = in_fire;
    for (int i = 1; i < STAGES; i++) begin
      src[i]    = dat[i-1];
      arrive[i] = vld[i-1] && rdy[i] && !stall && !flush[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      leave[i] = vld[i] && rdy[i+1] && !stall;
      if (flush[i]) begin
        vld_nxt[i] = 1'b0;
      end else if (arrive[i]) begin
        vld_nxt[i] = 1'b1;
        load[i]    = 1'b1;
      end else if (leave[i]) begin
        vld_nxt[i] = 1'b0;
      end
    end
  end

  // Valid bits and occupancy; occupancy tracks the count of the valid bits being loaded.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld       <= '0;
      occupancy <= '0;
    end else begin
      vld       <= vld_nxt;
      occupancy <= popcount(vld_nxt);
    end
  end

  // Payload registers only load when a stage accepts new data; invalid stages keep stale data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++)
        if (load[i]) dat[i] <= src[i];
    end
  end

`ifdef PIPE_PERF_EN
  // Saturating counters of frozen cycles and of cycles where the consumer waited on an empty output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (!stall && out_ready && !out_valid) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end
`endif

endmodule
